// File: rtl/norm_pkg.sv
// Shared constants and FSM encoding for the norm-squared / square-root datapath.
// NORM_SQRT_ROUND_EN adds the ROUND state used for round-to-nearest roots.
package norm_pkg;

  localparam int PRECIS    = 39;
  localparam int ROOT_BITS = (PRECIS + 1) / 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
`ifdef NORM_SQRT_ROUND_EN
    ,
    ROUND
`endif
  } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring bit-pair iteration of the integer square root.
// Resolves the next root bit from the partial remainder and root.
module sqrt_step #(
  parameter int ROOT_BITS = norm_pkg::ROOT_BITS
) (
  input  logic [ROOT_BITS+1:0] rem,
  input  logic [ROOT_BITS-1:0] root,
  input  logic [1:0]           pair,
  output logic [ROOT_BITS+1:0] rem_next,
  output logic [ROOT_BITS-1:0] root_next
);

  localparam int REM_W = ROOT_BITS + 2;

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] trial;
  logic             rem_top_unused;

  // An incoming remainder never exceeds twice a ROOT_BITS-1 bit partial root,
  // so its top two bits are zero and the trial fits REM_W bits in two's complement.
  assign shifted        = {rem[REM_W-3:0], pair};
  assign trial          = shifted - {root, 2'b01};
  assign rem_top_unused = ^rem[REM_W-1:REM_W-2];

  assign rem_next  = trial[REM_W-1] ? shifted : trial;
  assign root_next = {root[ROOT_BITS-2:0], ~trial[REM_W-1]};

endmodule

// File: rtl/norm_sqrt.sv
// Iterative integer square root of the norm-squared result, one root bit per cycle.
// Define NORM_SQRT_ROUND_EN to round the root to nearest via an extra ROUND cycle.
module norm_sqrt #(
  parameter int PRECIS    = norm_pkg::PRECIS,
  parameter int ROOT_BITS = norm_pkg::ROOT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PRECIS-1:0]    radicand,
  output logic [ROOT_BITS-1:0] root,
  output logic [ROOT_BITS:0]   rem,
  output logic                 busy,
  output logic                 done
);

  import norm_pkg::*;

  localparam int REM_W = ROOT_BITS + 2;
  localparam int RAD_W = 2 * ROOT_BITS;
  localparam int CNT_W = $clog2(ROOT_BITS);

  sqrt_state_t          state_q, state_d;
  logic [RAD_W-1:0]     rad_q;
  logic [ROOT_BITS-1:0] root_q, root_step;
  logic [REM_W-1:0]     rem_q, rem_step;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept;
  logic                 rem_msb_unused;

  assign accept = start && (state_q == IDLE || state_q == DONE);

  sqrt_step #(.ROOT_BITS(ROOT_BITS)) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .pair      (rad_q[RAD_W-1 -: 2]),
    .rem_next  (rem_step),
    .root_next (root_step)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaults first in every combinational block so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        if (cnt_q == '0) begin
`ifdef NORM_SQRT_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef NORM_SQRT_ROUND_EN
      ROUND: state_d = DONE;
`endif
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      CALC: busy = 1'b1;
`ifdef NORM_SQRT_ROUND_EN
      ROUND: busy = 1'b1;
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Radicand shifts left two bits per CALC cycle so the active pair is always the MSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      rad_q  <= RAD_W'(radicand);
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= CNT_W'(ROOT_BITS - 1);
    end else if (state_q == CALC) begin
      rad_q  <= rad_q << 2;
      root_q <= root_step;
      rem_q  <= rem_step;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
`ifdef NORM_SQRT_ROUND_EN
    else if (state_q == ROUND) begin
      // rem stays the floor remainder; only the reported root is bumped.
      if (rem_q > {2'b00, root_q}) root_q <= root_q + 1'b1;
    end
`endif
  end

  // The final remainder is at most 2*root, so the register MSB is always zero here.
  assign rem_msb_unused = rem_q[REM_W-1];
  assign root           = root_q;
  assign rem            = rem_q[ROOT_BITS:0];

endmodule

// File: tb/tb_norm_sqrt.sv
// Self-checking bench for norm_sqrt: directed cases plus a randomised radicand sweep
// checked against an arithmetic square-root model (tracks NORM_SQRT_ROUND_EN).
module tb_norm_sqrt;

  localparam int PRECIS = 39;
  localparam int RB     = 20;
  localparam longint MAX_RAD = (longint'(1) << PRECIS) - 1;
`ifdef NORM_SQRT_ROUND_EN
  localparam bit ROUND = 1'b1;
  localparam int LAT   = 21;
`else
  localparam bit ROUND = 1'b0;
  localparam int LAT   = 20;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [PRECIS-1:0] radicand;
  logic [RB-1:0]     root;
  logic [RB:0]       rem;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  norm_sqrt #(.PRECIS(PRECIS), .ROOT_BITS(RB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .radicand (radicand),
    .root     (root),
    .rem      (rem),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Floor square root from real arithmetic, corrected to the exact integer.
  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Expected reported root: floor, or nearest integer when rounding is built in.
  function automatic longint model_root(input longint x);
    longint f;
    f = isqrt(x);
    if (ROUND && (4 * x > (2 * f + 1) * (2 * f + 1))) return f + 1;
    return f;
  endfunction

  // Issue one request from IDLE or DONE and wait (bounded) for the done strobe.
  task automatic run_op(input longint x, output longint r, output longint m,
                        output int lat, output int busy_cycles);
    start    = 1'b1;
    radicand = x[PRECIS-1:0];
    @(posedge clk); #1;
    start       = 1'b0;
    radicand    = PRECIS'({$urandom, $urandom});
    busy_cycles = 0;
    lat         = -1;
    for (int k = 1; k <= 200; k++) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    r = longint'(root);
    m = longint'(rem);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b1;
    radicand = 39'd144;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (root !== '0) begin n_fail++; $display("FAIL reset_root: got %0d expected 0", root); end
    n_checks++; if (rem !== '0)  begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", rem); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    longint r, m;
    int lat, bc;
    run_op(144, r, m, lat, bc);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (bc != LAT)  begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, LAT); end
    n_checks++; if (r != 12) begin n_fail++; $display("FAIL basic_root: got %0d expected 12", r); end
    n_checks++; if (m != 0)  begin n_fail++; $display("FAIL basic_rem: got %0d expected 0", m); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (root !== 20'd12) begin n_fail++; $display("FAIL basic_hold_root: got %0d expected 12", root); end
    n_checks++; if (rem !== 21'd0)   begin n_fail++; $display("FAIL basic_hold_rem: got %0d expected 0", rem); end
  endtask

  task automatic test_corners();
    longint r, m;
    int lat, bc;
    longint exp_1000;
    exp_1000 = ROUND ? 32 : 31;
    run_op(0, r, m, lat, bc);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (r != 0) begin n_fail++; $display("FAIL zero_root: got %0d expected 0", r); end
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL zero_rem: got %0d expected 0", m); end
    @(posedge clk); #1;
    run_op(MAX_RAD, r, m, lat, bc);
    n_checks++; if (r != 741455) begin n_fail++; $display("FAIL max_root: got %0d expected 741455", r); end
    n_checks++; if (m != 296862) begin n_fail++; $display("FAIL max_rem: got %0d expected 296862", m); end
    @(posedge clk); #1;
    run_op(1000, r, m, lat, bc);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL r1000_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (r != exp_1000) begin n_fail++; $display("FAIL r1000_root: got %0d expected %0d", r, exp_1000); end
    n_checks++; if (m != 39) begin n_fail++; $display("FAIL r1000_rem: got %0d expected 39", m); end
  endtask

  task automatic test_ignore_start();
    int lat;
    start    = 1'b1;
    radicand = 39'd144;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 6) begin
        start    = 1'b1;
        radicand = 39'd25;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (root !== 20'd12) begin n_fail++; $display("FAIL ignore_root: got %0d expected 12", root); end
    n_checks++; if (rem !== 21'd0)   begin n_fail++; $display("FAIL ignore_rem: got %0d expected 0", rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    longint r, m;
    int lat, bc;
    run_op(144, r, m, lat, bc);
    n_checks++; if (r != 12) begin n_fail++; $display("FAIL b2b_first_root: got %0d expected 12", r); end
    run_op(25, r, m, lat, bc);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (r != 5) begin n_fail++; $display("FAIL b2b_root: got %0d expected 5", r); end
    n_checks++; if (m != 0) begin n_fail++; $display("FAIL b2b_rem: got %0d expected 0", m); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    longint r, m;
    int lat, bc;
    bit seen_done;
    start    = 1'b1;
    radicand = MAX_RAD[PRECIS-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (root !== '0) begin n_fail++; $display("FAIL abort_root: got %0d expected 0", root); end
    n_checks++; if (rem !== '0)  begin n_fail++; $display("FAIL abort_rem: got %0d expected 0", rem); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
    run_op(1000, r, m, lat, bc);
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (m != 39) begin n_fail++; $display("FAIL abort_restart_rem: got %0d expected 39", m); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    longint x, k, r, m, fr, er, em;
    int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0: x = longint'({$urandom, $urandom}) & MAX_RAD;
        1: x = (longint'({$urandom, $urandom}) & MAX_RAD) >> $urandom_range(38, 0);
        2: begin k = longint'($urandom_range(741455, 0)); x = k * k; end
        default: begin k = longint'($urandom_range(741454, 1)); x = k * k + 2 * k; end
      endcase
      run_op(x, r, m, lat, bc);
      fr = isqrt(x);
      er = model_root(x);
      em = x - fr * fr;
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency x=%0d: got %0d expected %0d", x, lat, LAT); end
      n_checks++; if (r != er) begin n_fail++; $display("FAIL rand_root x=%0d: got %0d expected %0d", x, r, er); end
      n_checks++; if (m != em) begin n_fail++; $display("FAIL rand_rem x=%0d: got %0d expected %0d", x, m, em); end
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    radicand = '0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_sqrt.md
NORM_SQRT -- requirements
Module: norm_sqrt

Interface
REQ-001 Parameter PRECIS, default 39, SHALL set the radicand width and match the norm-squared full-precision result width.
REQ-002 Parameter ROOT_BITS, default 20, SHALL equal (PRECIS+1)/2 and set the root width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one square-root operation on radicand; it is driven by the upstream norm-squared done strobe.
REQ-006 radicand  input  PRECIS  SHALL carry the unsigned full-precision norm squared and is sampled only when start is accepted.
REQ-007 root  output  ROOT_BITS  SHALL carry floor(sqrt(radicand)), or the rounded root when rounding is compiled in.
REQ-008 rem  output  ROOT_BITS+1  SHALL carry radicand - floor_root^2.
REQ-009 busy  output  1  SHALL be high while an operation is in progress.
REQ-010 done  output  1  SHALL be a one-cycle strobe marking root and rem valid.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, DONE, plus ROUND when rounding is compiled in.
REQ-012 In IDLE with start=1, the block SHALL register radicand, clear the partial root and remainder, set the iteration counter to ROOT_BITS-1, and go to CALC.
REQ-013 Each CALC cycle SHALL resolve one root bit, MSB first, by restoring bit-pair iteration.
- Trial = (rem<<2 | next radicand bit pair) - (root<<2 | 1).
- If trial >= 0: keep trial, shift in 1; else keep the shifted remainder, shift in 0.
REQ-014 In CALC with counter=0, the FSM SHALL go to DONE (or ROUND); otherwise the counter SHALL decrement.
REQ-015 Latency: done SHALL be high in the cycle after the ROOT_BITS-th rising edge following the edge that accepted start (20 edges by default; 21 with rounding).
REQ-016 done SHALL be high for exactly one cycle, in DONE; busy SHALL be high in CALC and ROUND, and low in IDLE and DONE.
REQ-017 root and rem SHALL hold their values from DONE until the next accepted start.
REQ-018 start during CALC or ROUND SHALL be ignored, with no queuing and no effect on the operand.
REQ-019 start in DONE SHALL be accepted as in IDLE (back-to-back operation); otherwise DONE SHALL return to IDLE.
REQ-020 Radicand 0 SHALL complete with normal latency and give root=0, rem=0.
REQ-021 No intermediate SHALL overflow: the remainder register SHALL be ROOT_BITS+2 bits wide, including the sign of the trial subtraction.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL set state=IDLE, root=0, rem=0, counter=0, busy=0 and done=0.
REQ-023 rst SHALL take priority over start.
REQ-024 rst during CALC or ROUND SHALL abort the operation with no done strobe.

Configuration
REQ-025 With NORM_SQRT_ROUND_EN defined, a ROUND state SHALL follow CALC.
- If rem > root, root SHALL be incremented by 1 (no overflow is possible at the PRECIS maximum).
- rem SHALL remain the unrounded remainder.
- Latency SHALL grow by one cycle.
REQ-026 With NORM_SQRT_ROUND_EN undefined, ROUND SHALL be absent and root SHALL be the floor root.

Structure
REQ-027 Package norm_pkg SHALL hold PRECIS, ROOT_BITS and the state encoding, shared with the norm-squared datapath.
REQ-028 One combinational sub-module, sqrt_step, SHALL implement a single bit-pair iteration: inputs rem, root, pair; outputs next rem, next root.

Verification
REQ-029 radicand=144, start pulse -> done 20 cycles later, root=12, rem=0, busy high for the 20 CALC cycles.
REQ-030 radicand=0 -> root=0, rem=0; radicand=549755813887 (all ones) -> root=741455, rem=296862.
REQ-031 radicand=1000 -> root=31, rem=39 without macro; root=32, rem=39 with NORM_SQRT_ROUND_EN, done at 21 cycles.
REQ-032 start with radicand=144, then start with radicand=25 at cycle 5 -> second request ignored, result root=12; start in DONE with radicand=25 -> root=5, rem=0.
REQ-033 rst asserted at cycle 10 of CALC -> no done, outputs 0, busy=0; a fresh start then completes normally.
REQ-034 Randomised radicand sweep (at least 1000 values) -> root^2 + rem == radicand and rem <= 2*root for every result.
